// File: rtl/eth_pkg.sv
// Shared Ethernet transmit-side definitions.
// Holds the packet-type encoding (also used as the arbiter grant code),
// the transmit arbiter state enum, and the default timing constants.
package eth_pkg;

  // Packet type; doubles as the grant/owner code on the transmit arbiter.
  typedef enum logic [1:0] {
    PKT_NONE = 2'b00,
    PKT_ARP  = 2'b01,
    PKT_UDP  = 2'b10
  } pkt_type_t;

  // Transmit arbiter states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_WAIT_EN = 3'd2,
    ST_SEND    = 3'd3,
    ST_IFG     = 3'd4
  } tx_arb_state_t;

  // Default minimum inter-frame gap in transmit clocks.
  localparam int DEF_IFG_CYCLES = 12;
  // Default cycles allowed from start pulse to first sender tx_en.
  localparam int DEF_START_TIMEOUT = 16;

endpackage

// File: rtl/eth_tx_arb.sv
// eth_tx_arb: shares one MII/GMII transmit port between the ARP and UDP
// frame senders. Requests are latched as pending bits, a round-robin pick
// grants one sender, a one-cycle start enable launches it, and its byte
// stream is forwarded (registered, one clock latency) to the PHY. Every
// frame (or start timeout) is followed by a fixed inter-frame gap.
//
// Ports:
//   clk, rst_n                      transmit clock, async active-low reset
//   i_arp_req, i_udp_req            frame requests (level or pulse)
//   o_arp_start, o_udp_start        one-cycle start enables to the senders
//   i_arp_tx_data/_en               ARP sender byte stream
//   i_udp_tx_data/_en               UDP sender byte stream
//   o_tx_data, o_tx_en              registered PHY transmit stream
//   o_grant                         current owner (pkt_type_t encoding)
//   o_busy                          arbiter not idle
//   o_arp_done, o_udp_done          one-cycle end-of-frame pulses
//   o_err                           one-cycle start-timeout pulse
module eth_tx_arb
  import eth_pkg::*;
#(
  parameter int IFG_CYCLES    = DEF_IFG_CYCLES,
  parameter int START_TIMEOUT = DEF_START_TIMEOUT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_arp_req,
  input  logic       i_udp_req,
  output logic       o_arp_start,
  output logic       o_udp_start,
  input  logic [7:0] i_arp_tx_data,
  input  logic       i_arp_tx_en,
  input  logic [7:0] i_udp_tx_data,
  input  logic       i_udp_tx_en,
  output logic [7:0] o_tx_data,
  output logic       o_tx_en,
  output logic [1:0] o_grant,
  output logic       o_busy,
  output logic       o_arp_done,
  output logic       o_udp_done,
  output logic       o_err
);

  localparam int CNT_MAX = (IFG_CYCLES > START_TIMEOUT) ? IFG_CYCLES : START_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  tx_arb_state_t    state_q, state_d;
  pkt_type_t        grant_q, grant_d;
  pkt_type_t        last_q, last_d;
  logic             pend_arp_q, pend_arp_d;
  logic             pend_udp_q, pend_udp_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             arp_start_q, arp_start_d;
  logic             udp_start_q, udp_start_d;
  logic             arp_done_q, arp_done_d;
  logic             udp_done_q, udp_done_d;
  logic             err_q, err_d;
  logic             busy_q;
  logic             tx_en_q, tx_en_d;
  logic [7:0]       tx_data_q, tx_data_d;
  pkt_type_t        pick_s;
  logic             gnt_en_s;
  logic [7:0]       gnt_data_s;
  logic             fwd_s;

  // Select the granted sender's stream; the other sender is ignored.
  always_comb begin
    gnt_en_s   = 1'b0;
    gnt_data_s = 8'h00;
    case (grant_q)
      PKT_ARP: begin
        gnt_en_s   = i_arp_tx_en;
        gnt_data_s = i_arp_tx_data;
      end
      PKT_UDP: begin
        gnt_en_s   = i_udp_tx_en;
        gnt_data_s = i_udp_tx_data;
      end
      default: begin
        gnt_en_s   = 1'b0;
        gnt_data_s = 8'h00;
      end
    endcase
  end

  // Round-robin pick: a lone pending source wins, a tie goes to the source
  // that was not served last.
  always_comb begin
    pick_s = PKT_NONE;
    if (pend_arp_q && pend_udp_q) begin
      pick_s = (last_q == PKT_ARP) ? PKT_UDP : PKT_ARP;
    end else if (pend_arp_q) begin
      pick_s = PKT_ARP;
    end else if (pend_udp_q) begin
      pick_s = PKT_UDP;
    end else begin
      pick_s = PKT_NONE;
    end
  end

  // Arbiter next-state, pending bookkeeping and pulse generation.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    timer_d     = timer_q;
    pend_arp_d  = pend_arp_q | i_arp_req;
    pend_udp_d  = pend_udp_q | i_udp_req;
    arp_start_d = 1'b0;
    udp_start_d = 1'b0;
    arp_done_d  = 1'b0;
    udp_done_d  = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_s != PKT_NONE) begin
          grant_d     = pick_s;
          state_d     = ST_START;
          // Start pulses are registered here so they are visible in START.
          arp_start_d = (pick_s == PKT_ARP);
          udp_start_d = (pick_s == PKT_UDP);
        end else begin
          grant_d = PKT_NONE;
        end
      end
      ST_START: begin
        // Clear only the granted bit; a request in this same cycle re-arms it.
        if (grant_q == PKT_ARP) begin
          pend_arp_d = i_arp_req;
        end else if (grant_q == PKT_UDP) begin
          pend_udp_d = i_udp_req;
        end else begin
          pend_arp_d = pend_arp_q | i_arp_req;
        end
        last_d  = grant_q;
        timer_d = '0;
        state_d = ST_WAIT_EN;
      end
      ST_WAIT_EN: begin
        // The START cycle is the first cycle of the timeout window, so the
        // abort fires START_TIMEOUT clocks after the start pulse.
        if (gnt_en_s) begin
          state_d = ST_SEND;
        end else if (timer_q == CNT_W'(START_TIMEOUT - 2)) begin
          err_d   = 1'b1;
          timer_d = '0;
          state_d = ST_IFG;
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      ST_SEND: begin
        if (!gnt_en_s) begin
          arp_done_d = (grant_q == PKT_ARP);
          udp_done_d = (grant_q == PKT_UDP);
          timer_d    = '0;
          state_d    = ST_IFG;
        end else begin
          state_d = ST_SEND;
        end
      end
      ST_IFG: begin
        if (timer_q == CNT_W'(IFG_CYCLES - 1)) begin
          grant_d = PKT_NONE;
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      default: begin
        grant_d = PKT_NONE;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Forward the granted stream only while a frame may be on the wire.
  always_comb begin
    fwd_s     = ((state_q == ST_WAIT_EN) || (state_q == ST_SEND)) && gnt_en_s;
    tx_en_d   = fwd_s;
    tx_data_d = fwd_s ? gnt_data_s : 8'h00;
  end

  // State, bookkeeping and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      grant_q     <= PKT_NONE;
      last_q      <= PKT_UDP;
      pend_arp_q  <= 1'b0;
      pend_udp_q  <= 1'b0;
      timer_q     <= '0;
      arp_start_q <= 1'b0;
      udp_start_q <= 1'b0;
      arp_done_q  <= 1'b0;
      udp_done_q  <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      tx_en_q     <= 1'b0;
      tx_data_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      pend_arp_q  <= pend_arp_d;
      pend_udp_q  <= pend_udp_d;
      timer_q     <= timer_d;
      arp_start_q <= arp_start_d;
      udp_start_q <= udp_start_d;
      arp_done_q  <= arp_done_d;
      udp_done_q  <= udp_done_d;
      err_q       <= err_d;
      busy_q      <= (state_d != ST_IDLE);
      tx_en_q     <= tx_en_d;
      tx_data_q   <= tx_data_d;
    end
  end

  assign o_arp_start = arp_start_q;
  assign o_udp_start = udp_start_q;
  assign o_arp_done  = arp_done_q;
  assign o_udp_done  = udp_done_q;
  assign o_err       = err_q;
  assign o_busy      = busy_q;
  assign o_grant     = grant_q;
  assign o_tx_en     = tx_en_q;
  assign o_tx_data   = tx_data_q;

endmodule

// File: tb/tb_eth_tx_arb.sv
// Randomized scoreboard bench for eth_tx_arb. A sender model answers start
// pulses with random frames and pushes the bytes it drives onto an expected
// queue; a negedge monitor pops and compares forwarded bytes and checks
// grant order against a pending-set / round-robin reference model.
module tb_eth_tx_arb;
  import eth_pkg::*;

  localparam int IFG = 12;
  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       arp_req = 1'b0, udp_req = 1'b0;
  logic       o_arp_start, o_udp_start;
  logic [7:0] arp_data = 8'h00, udp_data = 8'h00;
  logic       arp_en = 1'b0, udp_en = 1'b0;
  logic [7:0] o_tx_data;
  logic       o_tx_en;
  logic [1:0] o_grant;
  logic       o_busy, o_arp_done, o_udp_done, o_err;

  eth_tx_arb #(.IFG_CYCLES(IFG), .START_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_arp_req(arp_req), .i_udp_req(udp_req),
    .o_arp_start(o_arp_start), .o_udp_start(o_udp_start),
    .i_arp_tx_data(arp_data), .i_arp_tx_en(arp_en),
    .i_udp_tx_data(udp_data), .i_udp_tx_en(udp_en),
    .o_tx_data(o_tx_data), .o_tx_en(o_tx_en),
    .o_grant(o_grant), .o_busy(o_busy),
    .o_arp_done(o_arp_done), .o_udp_done(o_udp_done), .o_err(o_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard and sender controls.
  logic [7:0] exp_q[$];
  int         gnt_log[$];
  bit         udp_silent = 0, rogue = 0, mid_drop = 0, rand_mode = 0, abort = 0;
  int         force_len = 0;
  int         n_starts = 0, n_arp_done = 0, n_udp_done = 0, n_err = 0;

  // Sender model: answers each start pulse with a frame.
  initial begin : sender
    logic [7:0] d;
    int len, wt;
    bit u, drop;
    forever begin
      @(negedge clk);
      if (rst_n && (o_arp_start || o_udp_start) && !(o_udp_start && udp_silent)) begin
        u    = o_udp_start;
        len  = (force_len != 0) ? force_len : $urandom_range(1, 30);
        wt   = $urandom_range(1, 5);
        drop = mid_drop || (rand_mode && ($urandom_range(0, 3) == 0));
        repeat (wt) @(posedge clk);
        #1;
        for (int i = 0; i < len && !abort; i++) begin
          d = 8'($urandom_range(0, 255));
          if (d == 8'hAA) d = 8'h55;
          if (u) begin
            udp_en = 1'b1; udp_data = d;
          end else begin
            arp_en = 1'b1; arp_data = d;
            if (rogue) begin udp_en = 1'b1; udp_data = 8'hAA; end
          end
          exp_q.push_back(d);
          @(posedge clk); #1;
        end
        arp_en = 1'b0; udp_en = 1'b0; arp_data = 8'h00; udp_data = 8'h00;
        if (drop && !abort) begin
          // One idle cycle ends the frame; these late bytes must be dropped.
          @(posedge clk); #1;
          for (int i = 0; i < 3; i++) begin
            if (u) begin udp_en = 1'b1; udp_data = 8'hC0 + 8'(i); end
            else   begin arp_en = 1'b1; arp_data = 8'hC0 + 8'(i); end
            @(posedge clk); #1;
          end
          arp_en = 1'b0; udp_en = 1'b0; arp_data = 8'h00; udp_data = 8'h00;
        end
      end
    end
  end

  // Reference model state (pending sets + round robin) and monitor bookkeeping.
  bit        pend_a = 0, pend_u = 0, req_a_prev = 0, req_u_prev = 0;
  pkt_type_t last_m = PKT_UDP, clr_prev = PKT_NONE, clr_new, owner_m = PKT_NONE, pick;
  int        start_cyc = 0, end_cyc = 0, last_en_cyc = -1, gap;
  bit        prev_en = 0;
  logic [1:0] prev_grant = 2'b00;
  logic [7:0] exp_b;

  // Monitor: compares DUT outputs against scoreboard and model.
  always @(negedge clk) begin
    if (!rst_n) begin
      pend_a = 0; pend_u = 0; req_a_prev = 0; req_u_prev = 0;
      last_m = PKT_UDP; clr_prev = PKT_NONE; prev_en = 0; prev_grant = 2'b00;
    end else begin
      if (o_tx_en) begin
        if (!prev_en && last_en_cyc >= 0) begin
          gap = cyc - last_en_cyc - 1;
          n_tests++;
          if (gap < IFG + 3) begin
            n_fail++;
            $display("FAIL ifg_gap: got %0d idle cycles, need at least %0d", gap, IFG + 3);
          end
        end
        n_tests++;
        if (o_tx_data == 8'hAA) begin
          n_fail++;
          $display("FAIL no_foreign_byte: got 8'hAA from non-granted sender");
        end
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL extra_byte: got %0h expected no byte", o_tx_data);
        end else begin
          exp_b = exp_q.pop_front();
          check("tx_data", o_tx_data, exp_b);
        end
        last_en_cyc = cyc;
      end
      prev_en = o_tx_en;

      clr_new = PKT_NONE;
      if (o_arp_start || o_udp_start) begin
        if (pend_a && pend_u) pick = (last_m == PKT_ARP) ? PKT_UDP : PKT_ARP;
        else if (pend_a)      pick = PKT_ARP;
        else if (pend_u)      pick = PKT_UDP;
        else                  pick = PKT_NONE;
        check("start_arp", o_arp_start, pick == PKT_ARP);
        check("start_udp", o_udp_start, pick == PKT_UDP);
        check("grant", o_grant, pick);
        gnt_log.push_back(pick);
        owner_m = pick; last_m = pick; clr_new = pick;
        start_cyc = cyc; n_starts++;
      end

      if (o_arp_done || o_udp_done) begin
        check("done_src", {o_udp_done, o_arp_done}, owner_m);
        check("done_drain", exp_q.size(), 0);
        end_cyc = cyc;
        if (o_arp_done) n_arp_done++; else n_udp_done++;
      end
      if (o_err) begin
        check("err_latency", cyc - start_cyc, TMO);
        end_cyc = cyc; n_err++;
      end
      if (o_grant == 2'b00 && prev_grant != 2'b00) check("ifg_len", cyc - end_cyc, IFG);
      prev_grant = o_grant;

      // Pending update: the START edge clears the winner, a same-edge request re-sets it.
      if (clr_prev == PKT_ARP) pend_a = 0;
      if (clr_prev == PKT_UDP) pend_u = 0;
      pend_a = pend_a | req_a_prev;
      pend_u = pend_u | req_u_prev;
      clr_prev = clr_new;
      req_a_prev = arp_req;
      req_u_prev = udp_req;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_req(input bit a, input bit u);
    arp_req = a; udp_req = u;
    tick();
    arp_req = 1'b0; udp_req = 1'b0;
  endtask

  task automatic check_zero(input string name);
    check({name, "_tx_en"}, o_tx_en, 0);
    check({name, "_tx_data"}, o_tx_data, 0);
    check({name, "_grant"}, o_grant, 0);
    check({name, "_busy"}, o_busy, 0);
    check({name, "_starts"}, {o_arp_start, o_udp_start}, 0);
    check({name, "_pulses"}, {o_arp_done, o_udp_done, o_err}, 0);
  endtask

  task automatic wait_idle(input string name);
    int quiet = 0;
    int n = 0;
    while (quiet < 4 && n < 3000) begin
      @(negedge clk); n++;
      if (!o_busy && !arp_req && !udp_req) quiet++; else quiet = 0;
    end
    if (quiet < 4) begin
      n_tests++; n_fail++;
      $display("FAIL %s: arbiter still busy after %0d cycles", name, n);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    abort = 1'b1;
    repeat (3) tick();
    exp_q.delete();
    abort = 1'b0;
    last_en_cyc = -1;
    rst_n = 1'b1;
    tick();
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int base, d0, e0, u0, s0, n;
    repeat (3) tick();
    check_zero("reset");
    rst_n = 1'b1;
    tick();

    // Single ARP frame of 42 bytes; start appears two edges after request.
    force_len = 42;
    arp_req = 1'b1;
    tick();
    arp_req = 1'b0;
    check("arp_start_early", o_arp_start, 0);
    tick();
    check("arp_start_lat", o_arp_start, 1);
    check("arp_grant", o_grant, PKT_ARP);
    d0 = n_arp_done;
    wait_idle("single_arp");
    check("single_arp_done", n_arp_done - d0, 1);
    force_len = 0;

    // Simultaneous requests after reset: ARP first, then UDP.
    do_reset();
    base = gnt_log.size();
    pulse_req(1, 1);
    wait_idle("simultaneous");
    check("simul_count", gnt_log.size() - base, 2);
    if (gnt_log.size() - base >= 2) begin
      check("simul_first", gnt_log[base], PKT_ARP);
      check("simul_second", gnt_log[base + 1], PKT_UDP);
    end

    // Fairness with both requests held.
    base = gnt_log.size();
    arp_req = 1'b1; udp_req = 1'b1;
    n = 0;
    while (gnt_log.size() - base < 4 && n < 2000) begin tick(); n++; end
    arp_req = 1'b0; udp_req = 1'b0;
    wait_idle("fairness");
    check("fair_count_ge4", gnt_log.size() - base >= 4, 1);
    if (gnt_log.size() - base >= 4) begin
      check("fair_0", gnt_log[base],     PKT_ARP);
      check("fair_1", gnt_log[base + 1], PKT_UDP);
      check("fair_2", gnt_log[base + 2], PKT_ARP);
      check("fair_3", gnt_log[base + 3], PKT_UDP);
    end

    // Start timeout with a silent UDP sender, then normal service.
    udp_silent = 1;
    e0 = n_err;
    pulse_req(0, 1);
    wait_idle("timeout");
    check("timeout_err", n_err - e0, 1);
    udp_silent = 0;
    u0 = n_udp_done;
    pulse_req(0, 1);
    wait_idle("after_timeout");
    check("after_timeout_done", n_udp_done - u0, 1);

    // Interference from the non-granted UDP sender.
    rogue = 1;
    pulse_req(1, 0);
    wait_idle("interference");
    rogue = 0;

    // Mid-frame drop ends the frame.
    mid_drop = 1;
    d0 = n_arp_done;
    pulse_req(1, 0);
    wait_idle("mid_drop");
    check("mid_drop_done", n_arp_done - d0, 1);
    mid_drop = 0;

    // Random traffic.
    rand_mode = 1;
    for (int i = 0; i < 600; i++) begin
      arp_req = ($urandom_range(0, 15) == 0);
      udp_req = ($urandom_range(0, 15) == 0);
      tick();
    end
    arp_req = 1'b0; udp_req = 1'b0;
    wait_idle("random");
    rand_mode = 0;
    check("random_drain", exp_q.size(), 0);

    // Reset in the middle of a frame.
    force_len = 30;
    pulse_req(1, 0);
    n = 0;
    while (!o_tx_en && n < 100) begin @(negedge clk); n++; end
    check("mid_reset_sending", o_tx_en, 1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("async_reset");
    abort = 1'b1;
    repeat (3) tick();
    exp_q.delete();
    abort = 1'b0;
    force_len = 0;
    last_en_cyc = -1;
    rst_n = 1'b1;
    s0 = n_starts;
    repeat (30) tick();
    check("post_reset_no_start", n_starts - s0, 0);
    check("post_reset_busy", o_busy, 0);
    check("post_reset_grant", o_grant, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
